// File: rtl/matmul_tile_replayer_pkg.sv
// rtl/matmul_tile_replayer_pkg.sv - shared types and helpers for the matmul streaming blocks
package matmul_tile_replayer_pkg;

  // Replayer phases: accept one row-block, then replay it
  typedef enum logic {
    FILL   = 1'b0,
    REPLAY = 1'b1
  } state_e;

  // Counter width for a range of n values, never narrower than one bit
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/matmul_tile_replayer_if.sv
// rtl/matmul_tile_replayer_if.sv - input and output tile streams of the replayer
interface matmul_tile_replayer_if #(
  parameter int DATA_WIDTH = 8,
  parameter int LANES      = 4
);

  logic [DATA_WIDTH-1:0] data_in [LANES];
  logic                  data_in_valid;
  logic                  data_in_ready;
  logic [DATA_WIDTH-1:0] data_out [LANES];
  logic                  data_out_valid;
  logic                  data_out_ready;
  logic                  data_out_last_depth;
  logic                  data_out_last;

  // Environment side: drives upstream tiles and the core's ready
  modport master (
    output data_in, data_in_valid, data_out_ready,
    input  data_in_ready, data_out, data_out_valid, data_out_last_depth, data_out_last
  );

  // Replayer side
  modport slave (
    input  data_in, data_in_valid, data_out_ready,
    output data_in_ready, data_out, data_out_valid, data_out_last_depth, data_out_last
  );

endinterface

// File: rtl/matmul_tile_replayer_wrap_counter.sv
// rtl/matmul_tile_replayer_wrap_counter.sv - modulo-MAX event counter with wrap strobe
module matmul_tile_replayer_wrap_counter
  import matmul_tile_replayer_pkg::*;
#(
  parameter  int MAX = 3,
  localparam int W   = cnt_width(MAX)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] count,
  output logic         wrap
);

  localparam logic [W-1:0] LAST = W'(MAX - 1);

  // wrap marks the enabled event that takes the count from MAX-1 back to 0
  assign wrap = en && (count == LAST);

  // Advance on each enabled event; clr forces a restart from zero
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clr || wrap) begin
      count <= '0;
    end else if (en) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/matmul_tile_replayer.sv
// rtl/matmul_tile_replayer.sv - buffers one left-operand row-block and replays it REPEAT times
module matmul_tile_replayer
  import matmul_tile_replayer_pkg::*;
#(
  parameter int DATA_WIDTH      = 8,
  parameter int IN1_PARALLELISM = 4,
  parameter int IN_SIZE         = 1,
  parameter int IN_DEPTH        = 3,
  parameter int REPEAT          = 3
) (
  input logic                   clk,
  input logic                   rst,
  matmul_tile_replayer_if.slave bus
);

  localparam int LANES = IN1_PARALLELISM * IN_SIZE;
  localparam int DW    = cnt_width(IN_DEPTH);
  localparam int RW    = cnt_width(REPEAT);

  localparam logic [DW-1:0] RD_LAST  = DW'(IN_DEPTH - 1);
  localparam logic [RW-1:0] REP_LAST = RW'(REPEAT - 1);

  state_e                state;
  logic                  in_ready_q;
  logic                  out_valid_q;
  logic [DATA_WIDTH-1:0] tile_buf [IN_DEPTH][LANES];
  logic [DW-1:0]         wr_ptr;
  logic [DW-1:0]         rd_ptr;
  logic [RW-1:0]         rep_cnt;
  logic                  in_xfer;
  logic                  out_xfer;
  logic                  fill_done;
  logic                  rd_wrap;
  logic                  rep_wrap;
  logic                  last_depth;

  assign in_xfer  = bus.data_in_valid && in_ready_q;
  assign out_xfer = out_valid_q && bus.data_out_ready;

  // Write pointer wraps naturally on the final beat of a row-block
  matmul_tile_replayer_wrap_counter #(.MAX(IN_DEPTH)) u_wr_ptr (
    .clk   (clk),
    .rst   (rst),
    .en    (in_xfer),
    .clr   (1'b0),
    .count (wr_ptr),
    .wrap  (fill_done)
  );

  // Read pointer restarts at the beginning of every replay phase
  matmul_tile_replayer_wrap_counter #(.MAX(IN_DEPTH)) u_rd_ptr (
    .clk   (clk),
    .rst   (rst),
    .en    (out_xfer),
    .clr   (fill_done),
    .count (rd_ptr),
    .wrap  (rd_wrap)
  );

  // Pass counter steps once per completed pass; its wrap is the final beat
  matmul_tile_replayer_wrap_counter #(.MAX(REPEAT)) u_rep_cnt (
    .clk   (clk),
    .rst   (rst),
    .en    (rd_wrap),
    .clr   (fill_done),
    .count (rep_cnt),
    .wrap  (rep_wrap)
  );

  // Tile storage is not reset; it is only read while a full block is held
  always_ff @(posedge clk) begin
    if (in_xfer) begin
      tile_buf[wr_ptr] <= bus.data_in;
    end
  end

  // Phase control with registered handshake outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= FILL;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        FILL: begin
          if (fill_done) begin
            state       <= REPLAY;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b1;
          end
        end
        REPLAY: begin
          if (rep_wrap) begin
            state       <= FILL;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
          end
        end
        default: begin
          state       <= FILL;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign last_depth              = out_valid_q && (rd_ptr == RD_LAST);
  assign bus.data_in_ready       = in_ready_q;
  assign bus.data_out_valid      = out_valid_q;
  assign bus.data_out            = tile_buf[rd_ptr];
  assign bus.data_out_last_depth = last_depth;
  assign bus.data_out_last       = last_depth && (rep_cnt == REP_LAST);

endmodule

// File: tb/tb_matmul_tile_replayer.sv
// tb/tb_matmul_tile_replayer.sv - self-checking bench for matmul_tile_replayer
module tb_matmul_tile_replayer;

  localparam int DEPTH = 3;
  localparam int REP   = 3;
  localparam int LANES = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;

  always #5 clk = ~clk;

  // Posedge counter used to time-stamp transfers
  always @(posedge clk) cyc <= cyc + 1;

  matmul_tile_replayer_if #(.DATA_WIDTH(8), .LANES(LANES)) bus ();
  matmul_tile_replayer_if #(.DATA_WIDTH(8), .LANES(LANES)) bus1 ();

  matmul_tile_replayer #(
    .DATA_WIDTH(8), .IN1_PARALLELISM(4), .IN_SIZE(1), .IN_DEPTH(DEPTH), .REPEAT(REP)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  matmul_tile_replayer #(
    .DATA_WIDTH(8), .IN1_PARALLELISM(4), .IN_SIZE(1), .IN_DEPTH(1), .REPEAT(1)
  ) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [33:0] got_q[$];
  logic [33:0] exp_q[$];
  int          got_cyc[$];
  int          acc_cyc[$];
  bit          rdy_rand = 1'b0;
  bit          prev_stall = 1'b0;
  logic [33:0] prev_beat = '0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] out_word();
    return {bus.data_out[3], bus.data_out[2], bus.data_out[1], bus.data_out[0]};
  endfunction

  function automatic logic [33:0] out_beat();
    return {bus.data_out_last, bus.data_out_last_depth, out_word()};
  endfunction

  // Output monitor: records every transfer and checks holding during stalls
  always @(negedge clk) begin
    if (!rst) begin
      prev_stall <= 1'b0;
    end else begin
      if (prev_stall) check_eq("stall_hold", {30'd0, out_beat()}, {30'd0, prev_beat});
      if (bus.data_out_valid && bus.data_out_ready) begin
        got_q.push_back(out_beat());
        got_cyc.push_back(cyc);
      end
      prev_stall <= bus.data_out_valid && !bus.data_out_ready;
      prev_beat  <= out_beat();
    end
  end

  // Core-side ready: always high, or high about 30% of cycles
  always @(posedge clk) begin
    #1;
    bus.data_out_ready = rdy_rand ? ($urandom_range(0, 9) < 3) : 1'b1;
  end

  task automatic send_tile(input logic [31:0] w);
    bit ok;
    ok = 1'b0;
    for (int l = 0; l < LANES; l++) bus.data_in[l] = w[8*l +: 8];
    bus.data_in_valid = 1'b1;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      if (bus.data_in_ready) begin
        ok = 1'b1;
        acc_cyc.push_back(cyc);
      end
      @(posedge clk);
      #1;
    end
    bus.data_in_valid = 1'b0;
    check_eq("send_accept", {63'd0, ok}, 64'd1);
  endtask

  // Reference: each row-block comes out REP times in order, flags by beat position
  task automatic add_expect(input logic [31:0] blk[$]);
    for (int r = 0; r < REP; r++) begin
      for (int d = 0; d < blk.size(); d++) begin
        exp_q.push_back({(d == blk.size() - 1) && (r == REP - 1), d == blk.size() - 1, blk[d]});
      end
    end
  endtask

  task automatic check_beats(input string tag);
    for (int i = 0; i < 2000 && got_q.size() < exp_q.size(); i++) @(posedge clk);
    repeat (4) @(posedge clk);
    #1;
    check_eq({tag, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      check_eq($sformatf("%s_beat%0d", tag, i), {30'd0, got_q[i]}, {30'd0, exp_q[i]});
    end
  endtask

  task automatic clear_all();
    got_q.delete();
    exp_q.delete();
    got_cyc.delete();
    acc_cyc.delete();
  endtask

  function automatic logic [31:0] rand_tile();
    return $urandom();
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] blk[$];
    logic [31:0] blk2[$];
    bit          done;

    bus.data_in_valid  = 1'b0;
    bus.data_out_ready = 1'b1;
    bus1.data_in_valid  = 1'b0;
    bus1.data_out_ready = 1'b1;
    for (int l = 0; l < LANES; l++) begin
      bus.data_in[l]  = '0;
      bus1.data_in[l] = '0;
    end

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_out_valid", bus.data_out_valid, 0);
    check_eq("rst_last", bus.data_out_last, 0);
    check_eq("rst_last_depth", bus.data_out_last_depth, 0);
    @(posedge clk);
    #3 rst = 1'b1;
    @(negedge clk);
    check_eq("rst_in_ready", bus.data_in_ready, 1);
    check_eq("rst1_out_valid", bus1.data_out_valid, 0);
    @(posedge clk);
    #1;

    // Continuous flow with the lane/beat pattern
    blk.delete();
    for (int d = 0; d < DEPTH; d++) blk.push_back({8'(d + 48), 8'(d + 32), 8'(d + 16), 8'(d)});
    add_expect(blk);
    foreach (blk[d]) send_tile(blk[d]);
    for (int i = 0; i < REP * DEPTH; i++) begin
      @(negedge clk);
      check_eq("t1_in_ready_low", bus.data_in_ready, 0);
      check_eq("t1_out_valid", bus.data_out_valid, 1);
    end
    @(negedge clk);
    check_eq("t1_in_ready_back", bus.data_in_ready, 1);
    @(posedge clk);
    #1;
    check_eq("t1_n_out", got_cyc.size(), 9);
    if (got_cyc.size() == 9 && acc_cyc.size() == 3) begin
      check_eq("t1_first_latency", got_cyc[0], acc_cyc[2] + 1);
      check_eq("t1_last_time", got_cyc[8], acc_cyc[2] + 9);
    end
    check_beats("t1");
    clear_all();

    // Random backpressure on the output
    rdy_rand = 1'b1;
    blk.delete();
    for (int d = 0; d < DEPTH; d++) blk.push_back(rand_tile());
    add_expect(blk);
    foreach (blk[d]) send_tile(blk[d]);
    check_beats("t2");
    rdy_rand = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    clear_all();

    // Input gap of five cycles after the first tile
    blk.delete();
    for (int d = 0; d < DEPTH; d++) blk.push_back(rand_tile());
    add_expect(blk);
    send_tile(blk[0]);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq("t3_gap_no_out", bus.data_out_valid, 0);
      @(posedge clk);
      #1;
    end
    send_tile(blk[1]);
    send_tile(blk[2]);
    check_eq("t3_no_early_out", got_q.size(), 0);
    check_beats("t3");
    clear_all();

    // Reset in the middle of a replay
    blk.delete();
    for (int d = 0; d < DEPTH; d++) blk.push_back(rand_tile());
    foreach (blk[d]) send_tile(blk[d]);
    for (int i = 0; i < 200 && got_q.size() < 4; i++) @(posedge clk);
    #1;
    check_eq("t4_beats_before_rst", got_q.size(), 4);
    check_eq("t4_valid_before_rst", bus.data_out_valid, 1);
    #1 rst = 1'b0;
    #1;
    check_eq("t4_async_valid", bus.data_out_valid, 0);
    check_eq("t4_async_last", bus.data_out_last, 0);
    check_eq("t4_async_last_depth", bus.data_out_last_depth, 0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    @(negedge clk);
    check_eq("t4_in_ready", bus.data_in_ready, 1);
    @(posedge clk);
    #1;
    clear_all();
    blk.delete();
    for (int d = 0; d < DEPTH; d++) blk.push_back(rand_tile());
    add_expect(blk);
    foreach (blk[d]) send_tile(blk[d]);
    check_beats("t4");
    clear_all();

    // Single-beat, single-pass instance
    for (int l = 0; l < LANES; l++) bus1.data_in[l] = 8'hA5;
    bus1.data_in_valid = 1'b1;
    done = 1'b0;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (bus1.data_in_ready) done = 1'b1;
      @(posedge clk);
      #1;
    end
    bus1.data_in_valid = 1'b0;
    check_eq("t5_accept", {63'd0, done}, 64'd1);
    @(negedge clk);
    check_eq("t5_out_valid", bus1.data_out_valid, 1);
    check_eq("t5_data", {bus1.data_out[3], bus1.data_out[2], bus1.data_out[1], bus1.data_out[0]},
             32'hA5A5A5A5);
    check_eq("t5_last_depth", bus1.data_out_last_depth, 1);
    check_eq("t5_last", bus1.data_out_last, 1);
    check_eq("t5_in_ready_low", bus1.data_in_ready, 0);
    @(negedge clk);
    check_eq("t5_in_ready_back", bus1.data_in_ready, 1);
    check_eq("t5_out_idle", bus1.data_out_valid, 0);
    @(posedge clk);
    #1;

    // Two row-blocks back to back
    blk.delete();
    blk2.delete();
    for (int d = 0; d < DEPTH; d++) blk.push_back(rand_tile());
    for (int d = 0; d < DEPTH; d++) blk2.push_back(rand_tile());
    add_expect(blk);
    add_expect(blk2);
    foreach (blk[d]) send_tile(blk[d]);
    foreach (blk2[d]) send_tile(blk2[d]);
    check_eq("t6_acc_count", acc_cyc.size(), 6);
    if (acc_cyc.size() == 6 && got_cyc.size() >= 9) begin
      check_eq("t6_restart_cycle", acc_cyc[3], got_cyc[8] + 1);
    end
    check_beats("t6");
    clear_all();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/matmul_tile_replayer.md
Name: matmul_tile_replayer

Overview:
- Feeds the data_in1 (left-operand) stream of the fixed-point matmul core.
- The core consumes one row-block of the left matrix, IN_DEPTH beats of IN1_PARALLELISM*IN_SIZE elements, once per output column block.
- This block accepts each row-block exactly once from upstream, buffers it, and replays it REPEAT times in the same order on a valid/ready stream.
- Upstream therefore streams the left matrix only once.

Parameters:
- DATA_WIDTH, 8: element width in bits; the block is transparent to fixed-point format.
- IN1_PARALLELISM, 4: rows per tile.
- IN_SIZE, 1: columns per tile.
- IN_DEPTH, 3: beats per row-block; must be >= 1.
- REPEAT, 3: replays per row-block, equal to the number of output column blocks; must be >= 1.

Ports:
- clk  input  1  clock, all state updates on its rising edge.
- rst  input  1  asynchronous reset, active-low (asserted at 0).
- data_in  input  DATA_WIDTH x (IN1_PARALLELISM*IN_SIZE) unpacked  one tile from upstream.
- data_in_valid  input  1  upstream tile valid.
- data_in_ready  output  1  block can accept a tile.
- data_out  output  DATA_WIDTH x (IN1_PARALLELISM*IN_SIZE) unpacked  tile to the matmul core.
- data_out_valid  output  1  data_out valid.
- data_out_ready  input  1  matmul core accepts the tile.
- data_out_last_depth  output  1  high with the final beat (depth IN_DEPTH-1) of each replay pass.
- data_out_last  output  1  high with the final beat of the final pass.

Behaviour:
- Storage: register array buf[IN_DEPTH] of tiles. Counters: wr_ptr and rd_ptr, each 0..IN_DEPTH-1; rep_cnt, 0..REPEAT-1.
- Handshake: a transfer occurs when valid && ready on a rising edge. data_out_valid does not depend on data_out_ready. Once valid is raised, data_out and both flags stay stable until the transfer.
- FSM state FILL:
  - data_in_ready=1, data_out_valid=0.
  - On each input transfer: buf[wr_ptr] <= data_in and wr_ptr increments.
  - When the transfer at wr_ptr==IN_DEPTH-1 occurs: wr_ptr <= 0, rd_ptr <= 0, rep_cnt <= 0, go to REPLAY.
- FSM state REPLAY:
  - data_in_ready=0, data_out_valid=1, data_out=buf[rd_ptr] (combinational read of a registered array).
  - data_out_last_depth = (rd_ptr==IN_DEPTH-1).
  - data_out_last = data_out_last_depth && (rep_cnt==REPEAT-1).
  - On each output transfer rd_ptr increments. At IN_DEPTH-1 it wraps to 0 and rep_cnt increments.
  - On the transfer that has data_out_last=1: rd_ptr <= 0, rep_cnt <= 0, go to FILL.
- Latency and throughput:
  - First output beat is valid in the cycle after the last input transfer.
  - data_in_ready rises in the cycle after the last output transfer.
  - Fill and replay never overlap. With no stalls, one row-block takes IN_DEPTH*(1+REPEAT) cycles.
- Output stall: if data_out_ready is held at 0, every pointer and output is held.
- Input stall: if data_in_valid drops mid-fill, wr_ptr holds and the partial buffer is kept.
- Boundaries:
  - IN_DEPTH=1: data_out_last_depth is high on every beat.
  - REPEAT=1: plain store-and-forward of one row-block.
  - Both =1: exactly one beat out per beat in, with data_out_last=1.
- Reset (rst=0), at any time including mid-fill or mid-replay:
  - State <= FILL; wr_ptr, rd_ptr, rep_cnt <= 0.
  - data_out_valid=0, data_out_last=0, data_out_last_depth=0; data_in_ready=1 after reset release.
  - buf contents are not reset; data_out is don't-care while data_out_valid=0.
- Pointer widths: $clog2 of the range, minimum 1 bit. No arithmetic is applied to the data.

Decomposition:
- Shared package:
  - FSM state enum {FILL, REPLAY}.
  - Function computing a counter width as max(1,$clog2(n)), reused by the other matmul streaming blocks.
- One sub-module is natural: wrap_counter (parameter MAX; ports clk, rst, en, clr, count, wrap).
  - Instantiated three times: wr_ptr, rd_ptr, rep_cnt.
  - rep_cnt is enabled by the rd_ptr wrap.

Test Plan:
- Defaults, continuous valid/ready. Tiles T0,T1,T2 in (each element = beat index + 16*lane).
  - Required: out sequence T0,T1,T2 x3 (9 beats).
  - data_out_last_depth on beats 2, 5, 8; data_out_last on beat 8 only.
  - data_in_ready=0 from the cycle after T2 accepted through beat 8; first output in the cycle after T2 accepted.
- Random data_out_ready at 30% duty.
  - Required: data_out and flags stable across every stall; identical 9-beat sequence; no beat dropped or duplicated.
- data_in_valid low for 5 cycles after T0, then T1,T2.
  - Required: no output before T2 is accepted; replay order is still T0,T1,T2.
- Reset asserted after 4 output beats.
  - Required: outputs go low asynchronously; data_in_ready=1 after release.
  - A new row-block U0..U2 replays as U0..U2 x3 with no T-data leaked.
- IN_DEPTH=1, REPEAT=1.
  - Input 0xA5 in all lanes. Required: one output beat of 0xA5 with last_depth=1 and last=1; data_in_ready returns the following cycle.
- Two back-to-back row-blocks, ready always high.
  - Required: 18 output beats; the second block starts accepting exactly one cycle after the first block's data_out_last transfer.
